// File: rtl/t07_mem_responder_if.sv
// Wishbone-style single-beat bus between the t07 memory responder and the SRAM/bus fabric.
// The responder uses the master modport. The fabric or bench uses the slave modport.
interface t07_mem_responder_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack;

    modport master (
        output cyc, stb, we, sel, adr, dat_o,
        input  dat_i, ack
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_o,
        output dat_i, ack
    );
endinterface

// File: rtl/t07_mem_responder.sv
// Memory-side responder for the t07 CPU: each fetch, read or write request becomes one
// single-beat bus transfer. The CPU is frozen until the transfer acks or times out.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a request; a legal rwi launches a bus cycle
// WAIT  | bus cycle active; wait for bus_ack or timeout
// DONE  | result valid, freeze low; stale rwi ignored, back to IDLE
module t07_mem_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] RESET_INST     = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           rwi,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          inst,
    output logic [31:0]          rdata,
    output logic                 freeze,
    output logic                 err_timeout,
    output logic                 err_illegal,
    t07_mem_responder_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        KIND_FETCH = 2'd0,
        KIND_READ  = 2'd1,
        KIND_WRITE = 2'd2
    } kind_t;

    localparam logic [2:0]  RWI_IDLE  = 3'b000;
    localparam logic [2:0]  RWI_FETCH = 3'b001;
    localparam logic [2:0]  RWI_READ  = 3'b010;
    localparam logic [2:0]  RWI_WRITE = 3'b100;
    // The counter holds the number of unacked WAIT cycles already spent. This value marks the last allowed one.
    localparam logic [15:0] CNT_LAST  = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    kind_t       kind_q, kind_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_timeout_q, err_timeout_d;
    logic        err_illegal_q, err_illegal_d;
    logic        bus_cyc_q, bus_cyc_d;
    logic        bus_stb_q, bus_stb_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_adr_q, bus_adr_d;
    logic [31:0] bus_dat_o_q, bus_dat_o_d;
    logic        rwi_legal;

    assign rwi_legal = (rwi == RWI_FETCH) || (rwi == RWI_READ) || (rwi == RWI_WRITE);

    always_comb begin
        state_d       = state_q;
        kind_d        = kind_q;
        cnt_d         = cnt_q;
        inst_d        = inst_q;
        rdata_d       = rdata_q;
        err_timeout_d = err_timeout_q;
        err_illegal_d = err_illegal_q;
        bus_cyc_d     = bus_cyc_q;
        bus_stb_d     = bus_stb_q;
        bus_we_d      = bus_we_q;
        bus_adr_d     = bus_adr_q;
        bus_dat_o_d   = bus_dat_o_q;

        case (state_q)
            ST_IDLE: begin
                if (rwi_legal) begin
                    bus_adr_d   = addr & 32'hFFFF_FFFC;
                    bus_we_d    = (rwi == RWI_WRITE);
                    bus_dat_o_d = wdata;
                    bus_cyc_d   = 1'b1;
                    bus_stb_d   = 1'b1;
                    cnt_d       = 16'd0;
                    state_d     = ST_WAIT;
                    if (rwi == RWI_FETCH) begin
                        kind_d = KIND_FETCH;
                    end else if (rwi == RWI_READ) begin
                        kind_d = KIND_READ;
                    end else begin
                        kind_d = KIND_WRITE;
                    end
                end else if (rwi != RWI_IDLE) begin
                    err_illegal_d = 1'b1;
                end
            end

            ST_WAIT: begin
                // Ack is checked first, so an ack on the last allowed cycle still completes cleanly.
                if (bus.ack) begin
                    if (kind_q == KIND_FETCH) begin
                        inst_d = bus.dat_i;
                    end else if (kind_q == KIND_READ) begin
                        rdata_d = bus.dat_i;
                    end
                    bus_cyc_d = 1'b0;
                    bus_stb_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_timeout_d = 1'b1;
                    if (kind_q == KIND_FETCH) begin
                        inst_d = RESET_INST;
                    end else if (kind_q == KIND_READ) begin
                        rdata_d = 32'd0;
                    end
                    bus_cyc_d = 1'b0;
                    bus_stb_d = 1'b0;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            kind_q        <= KIND_FETCH;
            cnt_q         <= 16'd0;
            inst_q        <= RESET_INST;
            rdata_q       <= 32'd0;
            err_timeout_q <= 1'b0;
            err_illegal_q <= 1'b0;
            bus_cyc_q     <= 1'b0;
            bus_stb_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_adr_q     <= 32'd0;
            bus_dat_o_q   <= 32'd0;
        end else begin
            state_q       <= state_d;
            kind_q        <= kind_d;
            cnt_q         <= cnt_d;
            inst_q        <= inst_d;
            rdata_q       <= rdata_d;
            err_timeout_q <= err_timeout_d;
            err_illegal_q <= err_illegal_d;
            bus_cyc_q     <= bus_cyc_d;
            bus_stb_q     <= bus_stb_d;
            bus_we_q      <= bus_we_d;
            bus_adr_q     <= bus_adr_d;
            bus_dat_o_q   <= bus_dat_o_d;
        end
    end

    // Freeze is combinational so that the CPU stalls in the same cycle that it presents the request.
    assign freeze = !rst && (((state_q == ST_IDLE) && rwi_legal) || (state_q == ST_WAIT));

    assign inst        = inst_q;
    assign rdata       = rdata_q;
    assign err_timeout = err_timeout_q;
    assign err_illegal = err_illegal_q;
    assign bus.cyc     = bus_cyc_q;
    assign bus.stb     = bus_stb_q;
    assign bus.we      = bus_we_q;
    assign bus.sel     = 4'hF;
    assign bus.adr     = bus_adr_q;
    assign bus.dat_o   = bus_dat_o_q;

endmodule

// File: doc/t07_mem_responder.md
Name: t07_mem_responder

Overview:
- Memory-side responder for the t07 CPU's external memory request interface.
- Accepts the CPU's `rwi`/`addr`/write-data requests and runs each one as a single-beat word transfer on a Wishbone-style bus.
- Returns the fetched instruction or read data to the CPU, and holds `freeze` high until the transfer completes.
- Sits between the CPU core and the external SRAM/bus fabric.

Parameters:
- TIMEOUT_CYCLES, 255: maximum WAIT cycles without `bus_ack` before the transfer is abandoned (legal range 1..65535).
- RESET_INST, 32'h0000_0013: value of `inst` after reset (RV32 NOP).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- rwi  in  3  request: 3'b000 idle, 3'b001 instruction fetch, 3'b010 data read, 3'b100 data write; every other code is illegal.
- addr  in  32  byte address from the CPU; bits [1:0] are ignored.
- wdata  in  32  store data from the CPU.
- inst  out  32  last fetched instruction (registered).
- rdata  out  32  last data-read result (registered).
- freeze  out  1  CPU stall request (combinational).
- err_timeout  out  1  sticky; set when a transfer times out.
- err_illegal  out  1  sticky; set when an illegal `rwi` code is seen in IDLE.
- bus_cyc  out  1  bus cycle active.
- bus_stb  out  1  bus strobe.
- bus_we  out  1  1 = write.
- bus_sel  out  4  byte lanes; always 4'hF.
- bus_adr  out  32  word-aligned address, {addr[31:2], 2'b00}.
- bus_dat_o  out  32  write data.
- bus_dat_i  in  32  read data.
- bus_ack  in  1  transfer acknowledge.

Behaviour:
- Reset (rst high at a clk edge) drives the following; applies mid-transfer too:
  - state ← IDLE;
  - `inst` ← RESET_INST; `rdata` ← 0;
  - both error flags cleared;
  - all bus_* outputs ← 0, except `bus_sel` = 4'hF;
  - WAIT counter ← 0.
- An aborted transfer is not retried. A late `bus_ack` arriving in IDLE is ignored.
- `freeze` = !rst && ((state == IDLE && rwi is a legal nonzero code) || state == WAIT). It is 0 in DONE and during reset.
- FSM states: IDLE, WAIT, DONE.
- IDLE with a legal nonzero `rwi`:
  - register `bus_adr`, `bus_we` (= rwi==3'b100), `bus_dat_o` = `wdata`, and the request kind;
  - set `bus_cyc` = `bus_stb` = 1; clear the WAIT counter;
  - go to WAIT.
- IDLE with 3'b000: stay in IDLE, no bus activity.
- IDLE with an illegal `rwi`: set `err_illegal`, stay in IDLE, no bus activity, `freeze` = 0.
- WAIT with `bus_ack` = 1:
  - fetch: `inst` ← `bus_dat_i`;
  - read: `rdata` ← `bus_dat_i`;
  - write: neither register changes;
  - in all cases `bus_cyc`, `bus_stb` ← 0 and go to DONE.
- WAIT without ack: increment the counter. When the counter reaches TIMEOUT_CYCLES:
  - set `err_timeout`;
  - fetch: `inst` ← RESET_INST; read: `rdata` ← 0; write: no register update;
  - drop `cyc`/`stb` and go to DONE.
- Ack and timeout in the same cycle: ack wins and `err_timeout` is not set.
- DONE: `freeze` = 0, so the CPU advances on this edge. `rwi` is ignored (it is the stale request). Always go to IDLE next cycle.
- Minimum latency: request seen in cycle 0 (freeze 1), WAIT with ack in cycle 1 (freeze 1), DONE in cycle 2 (freeze 0, data valid). Each ack delay cycle adds one cycle.
- The CPU holds `rwi`, `addr` and `wdata` stable while `freeze` = 1. The responder samples them only in IDLE.
- `inst` and `rdata` hold their values between transfers of their own kind.
- Bus outputs remain stable throughout WAIT.
- `bus_dat_o` and `bus_adr` retain their last values when idle; only `cyc`/`stb` return to 0.

Test Plan:
- Fetch, zero wait: rwi=001, addr=0x0000_0104, ack in the first WAIT cycle with bus_dat_i=0x00A0_0093 -> bus_adr=0x104, bus_we=0, freeze high for 2 cycles, inst=0x00A0_0093 in DONE, rdata unchanged.
- Write with 3 wait states: rwi=100, addr=0x2000_0007, wdata=0xCAFE_F00D -> bus_adr=0x2000_0004, bus_we=1, bus_dat_o=0xCAFE_F00D held 4 WAIT cycles, freeze high for 5 cycles total, inst/rdata unchanged.
- Back-to-back: read 0x10 (ack data 0x1111_1111), then fetch 0x14 presented in DONE and held -> the DONE cycle does not relaunch, the fetch starts in the following IDLE, rdata=0x1111_1111, then inst equals the fetch data.
- Timeout: TIMEOUT_CYCLES=4, read with no ack -> err_timeout=1 after 4 WAIT cycles, rdata=0, freeze drops in DONE, a later ack in IDLE is ignored, the flag stays set until rst.
- Illegal code: rwi=011 in IDLE -> err_illegal=1, no bus_cyc, freeze=0; rwi=000 afterwards leaves the flag set.
- Reset mid-WAIT: assert rst during WAIT of a fetch -> next cycle bus_cyc=0, inst=0x0000_0013, both flags 0, freeze=0; an ack arriving after reset changes nothing.
